audio_pwm_player: RTL and testbench
===================================

// Module: audio_pwm_player
// PURPOSE
//  Downstream consumer of the sample RAM read path: accepts 16-bit signed audio samples via
//  valid/ready, buffers them in a small FIFO, pops one per ~31.5 kHz sample tick and drives a
//  mono PWM audio pin (Nexys-style AUD_PWM/AUD_SD). Also exports the sample tick so the RAM
//  address sequencer can advance in lock-step with playback.
// PARAMETERS
//  DEPTH     4     FIFO entries; power of two, 2..16
//  TICK_DIV  3175  clk cycles per sample tick (100 MHz / 3175 = 31.496 kHz); >= 2^PWM_BITS
//  PWM_BITS  10    PWM resolution; carrier = clk / 2^PWM_BITS (97.66 kHz at default)
// PORTS
//  clk           in   1         system clock, 100 MHz
//  rst           in   1         asynchronous, active-low reset
//  enable        in   1         1 = play; 0 = stop ticks, drive silence, FIFO still accepts
//  sample_valid  in   1         upstream has a sample on sample_data
//  sample_data   in   16        signed two's-complement PCM sample
//  sample_ready  out  1         FIFO can accept (not full)
//  underrun_clr  in   1         single-cycle pulse clears underrun
//  sample_tick   out  1         one-cycle pulse every TICK_DIV cycles while enable=1
//  fifo_level    out  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
//  underrun      out  1         sticky: a tick found the FIFO empty
//  AUD_PWM       out  1         PWM audio output
//  AUD_SD        out  1         amplifier enable (= registered enable)
// BEHAVIOUR
//  Reset (rst=0, async): FIFO empty, fifo_level=0, sample_ready=1, sample_tick=0, underrun=0,
//   tick counter=0, PWM counter=0, current sample=0 (midscale), AUD_PWM=0, AUD_SD=0.
//  FIFO: push when sample_valid & sample_ready at posedge. sample_ready = (fifo_level!=DEPTH),
//   combinational from registered level. Pointers wrap modulo DEPTH. Push and pop in the same
//   cycle: both happen, level unchanged; legal even when full (ready still 0 that cycle, so no
//   push) or empty (pop sees empty -> underrun, push still lands).
//  Tick: counter 0..TICK_DIV-1 runs only while enable=1; sample_tick=1 in the cycle counter
//   wraps TICK_DIV-1 -> 0. enable=0 holds counter at 0 and forces sample_tick=0, so first tick
//   after enable rises is exactly TICK_DIV cycles later.
//  Pop: on sample_tick, if level>0 the head entry loads cur_sample next cycle (1-cycle latency
//   tick->cur_sample); if empty, cur_sample holds previous value and underrun sets.
//  underrun: set by empty-tick, cleared by underrun_clr; set wins if both in same cycle.
//  Duty: duty = {~cur_sample[15], cur_sample[14:16-PWM_BITS]} (offset-binary, truncating).
//   -32768 -> 0, 0 -> 2^(PWM_BITS-1), +32767 -> 2^PWM_BITS-1.
//  PWM: free-running PWM_BITS counter pwm_cnt; duty latched into duty_q only when pwm_cnt wraps
//   to 0 (glitch-free carrier). AUD_PWM registered = enable_q & (pwm_cnt < duty_q). Duty 0 ->
//   constant 0; max duty -> low for exactly 1 of 2^PWM_BITS cycles.
//  enable: registered into enable_q/AUD_SD; enable_q=0 forces AUD_PWM=0, does not flush FIFO
//   or cur_sample. Async reset mid-playback discards FIFO contents and returns all to reset values.
//  No states beyond FIFO/counters; no combinational path from sample_valid to sample_ready.
// TESTING
//  1 Reset: hold rst=0 with valid=1 -> ready=1, level=0, AUD_PWM=0, AUD_SD=0, no push occurs.
//  2 Fill: enable=0, push 5 samples back-to-back -> level 1,2,3,4; ready=0 after 4th; 5th
//    held by upstream and accepted only after a pop; no tick pulses while enable=0.
//  3 Playback: push 0x0000,0x7FFF,0x8000, enable=1 -> tick every 3175 cycles; duty_q 512,
//    1023, 0 in order; measured AUD_PWM high counts 512/1023/0 per 1024-cycle period.
//  4 Underrun: 1 sample queued, run 2 ticks -> underrun=1 at 2nd tick, cur_sample unchanged;
//    underrun_clr pulse in same cycle as a 3rd empty tick -> underrun stays 1.
//  5 Simultaneous push/pop at level=0 and level=DEPTH-1 -> level and data order correct.
//  6 Async reset at pwm_cnt=300 mid-tick -> all outputs to reset values without a clock edge.

Source files
------------

// File: rtl/audio_pwm_player.sv
// Mono PWM audio player: a small sample FIFO that is drained at the audio sample rate,
// with each sample converted to an offset-binary duty cycle on a free-running PWM carrier.
module audio_pwm_player #(
    parameter int DEPTH    = 4,
    parameter int TICK_DIV = 3175,
    parameter int PWM_BITS = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     sample_valid,
    input  logic [15:0]              sample_data,
    output logic                     sample_ready,
    input  logic                     underrun_clr,
    output logic                     sample_tick,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun,
    output logic                     AUD_PWM,
    output logic                     AUD_SD
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TICK_DIV);

    logic [15:0]         mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [TW-1:0]       tick_cnt;
    logic [15:0]         cur_sample;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_q;
    logic                enable_q;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic                unused_lsbs;

    assign sample_ready = (fifo_level != LW'(DEPTH));
    assign push         = sample_valid & sample_ready;
    assign fifo_empty   = (fifo_level == '0);
    assign pop          = sample_tick & ~fifo_empty;
    assign AUD_SD       = enable_q;

    // Flipping the sign bit turns two's complement into offset binary; low bits are dropped.
    assign duty        = {~cur_sample[15], cur_sample[14:16-PWM_BITS]};
    assign unused_lsbs = ^cur_sample[15-PWM_BITS:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= sample_data;
        end
    end

    // Sample-rate divider; held at zero while disabled so playback restarts a full period later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt    <= '0;
            sample_tick <= 1'b0;
        end else if (!enable) begin
            tick_cnt    <= '0;
            sample_tick <= 1'b0;
        end else if (tick_cnt == TW'(TICK_DIV - 1)) begin
            tick_cnt    <= '0;
            sample_tick <= 1'b1;
        end else begin
            tick_cnt    <= tick_cnt + 1'b1;
            sample_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            cur_sample <= '0;
            underrun   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                cur_sample <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            // An empty tick outranks a simultaneous clear so no underrun is ever lost.
            if (sample_tick && fifo_empty) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

    // Duty only changes at the carrier wrap, so no PWM period ever mixes two duty values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_cnt  <= '0;
            duty_q   <= '0;
            enable_q <= 1'b0;
            AUD_PWM  <= 1'b0;
        end else begin
            pwm_cnt  <= pwm_cnt + 1'b1;
            enable_q <= enable;
            AUD_PWM  <= enable_q & (pwm_cnt < duty_q);
            if (pwm_cnt == '1) begin
                duty_q <= duty;
            end
        end
    end

endmodule

// File: tb/tb_audio_pwm_player.sv
// Testbench for audio_pwm_player: random and directed sample streams, with a queue-based
// reference of the FIFO whose pops drive expected PWM duty and underrun results.
module tb_audio_pwm_player;

    localparam int DEPTH    = 4;
    localparam int TICK_DIV = 600;
    localparam int PWM_BITS = 8;
    localparam int PERIOD   = 1 << PWM_BITS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic        underrun_clr = 1'b0;
    logic        sample_ready;
    logic        sample_tick;
    logic [2:0]  fifo_level;
    logic        underrun;
    logic        AUD_PWM;
    logic        AUD_SD;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_q[$];
    int          meas_q[$];
    bit          exp_underrun = 1'b0;
    bit          empty_tick_now = 1'b0;
    bit          acc_pend = 1'b0;
    bit          prev_en = 1'b0;
    bit          chk_ur = 1'b0;
    int          last_duty = PERIOD / 2;
    int          gap = -1;

    audio_pwm_player #(
        .DEPTH(DEPTH),
        .TICK_DIV(TICK_DIV),
        .PWM_BITS(PWM_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .sample_valid(sample_valid),
        .sample_data(sample_data),
        .sample_ready(sample_ready),
        .underrun_clr(underrun_clr),
        .sample_tick(sample_tick),
        .fifo_level(fifo_level),
        .underrun(underrun),
        .AUD_PWM(AUD_PWM),
        .AUD_SD(AUD_SD)
    );

    always #5 clk = ~clk;

    // Offset-binary duty from a signed sample: shift into 0..65535, keep the top PWM_BITS.
    function automatic int dutyOf(input logic [15:0] s);
        return (int'($signed(s)) + 32768) >> (16 - PWM_BITS);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then commit the accepted push / clear into the model.
    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic en,
                                 input logic clr);
        sample_valid = v;
        sample_data  = d;
        enable       = en;
        underrun_clr = clr;
        acc_pend     = v && sample_ready;
        @(posedge clk);
        #1;
        if (acc_pend) exp_q.push_back(d);
        if (clr && !empty_tick_now) exp_underrun = 1'b0;
        checkOutput("fifo_level", int'(fifo_level), exp_q.size());
        checkOutput("sample_ready", int'(sample_ready), int'(exp_q.size() != DEPTH));
        checkOutput("AUD_SD", int'(AUD_SD), int'(en));
    endtask

    task automatic waitTick();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 2 * TICK_DIV && !got; i++) begin
            applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
            got = sample_tick;
        end
        checkOutput("tick_seen", int'(got), 1);
    endtask

    // Reset is asserted between clock edges so its effect must be purely asynchronous.
    task automatic resetDut(input logic v);
        #2;
        rst          = 1'b0;
        sample_valid = v;
        enable       = 1'b0;
        underrun_clr = 1'b0;
        #1;
        checkOutput("rst_ready", int'(sample_ready), 1);
        checkOutput("rst_level", int'(fifo_level), 0);
        checkOutput("rst_pwm", int'(AUD_PWM), 0);
        checkOutput("rst_sd", int'(AUD_SD), 0);
        checkOutput("rst_tick", int'(sample_tick), 0);
        checkOutput("rst_underrun", int'(underrun), 0);
        exp_q.delete();
        meas_q.delete();
        exp_underrun = 1'b0;
        last_duty    = PERIOD / 2;
        acc_pend     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_no_push", int'(fifo_level), 0);
        rst          = 1'b1;
        sample_valid = 1'b0;
    endtask

    // Tick monitor: checks tick spacing, pops the model FIFO and queues the expected duty.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                gap            = -1;
                prev_en        = 1'b0;
                empty_tick_now = 1'b0;
                chk_ur         = 1'b0;
            end else begin
                empty_tick_now = 1'b0;
                if (chk_ur) begin
                    checkOutput("underrun", int'(underrun), int'(exp_underrun));
                    chk_ur = 1'b0;
                end
                gap = enable ? gap + 1 : -1;
                if (sample_tick) begin
                    checkOutput("tick_while_enabled", int'(prev_en), 1);
                    checkOutput("tick_period", gap, TICK_DIV);
                    gap = 0;
                    if (exp_q.size() > 0) begin
                        last_duty = dutyOf(exp_q.pop_front());
                    end else begin
                        exp_underrun   = 1'b1;
                        empty_tick_now = 1'b1;
                    end
                    meas_q.push_back(last_duty);
                    chk_ur = 1'b1;
                end
                prev_en = enable;
            end
        end
    end

    // PWM monitor: once the new duty has settled, count high cycles over one full carrier period.
    initial begin
        forever begin
            @(negedge clk);
            if (meas_q.size() > 0) begin
                int e;
                int hi;
                e  = meas_q.pop_front();
                hi = 0;
                repeat (PERIOD + 2) @(negedge clk);
                repeat (PERIOD) begin
                    @(negedge clk);
                    hi += int'(AUD_PWM);
                end
                checkOutput("pwm_high_count", hi, e);
            end
        end
    end

    initial begin
        logic [15:0] fill [5];
        logic [15:0] rd;
        logic        rv;
        bit          got;
        int          hi;

        resetDut(1'b1);

        fill[0] = 16'h0000;
        fill[1] = 16'h7FFF;
        fill[2] = 16'h8000;
        fill[3] = 16'($urandom);
        fill[4] = 16'($urandom);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, fill[i], 1'b0, 1'b0);
        checkOutput("full_ready_low", int'(sample_ready), 0);

        hi = 0;
        repeat (300) begin
            applyStimulus(1'b1, fill[4], 1'b0, 1'b0);
            hi += int'(AUD_PWM);
        end
        checkOutput("pwm_muted_when_disabled", hi, 0);
        checkOutput("fifth_held", int'(fifo_level), DEPTH);

        got = 1'b0;
        for (int i = 0; i < 2 * TICK_DIV && !got; i++) begin
            applyStimulus(1'b1, fill[4], 1'b1, 1'b0);
            got = acc_pend;
        end
        checkOutput("fifth_accepted", int'(got), 1);

        for (int i = 0; i < DEPTH + 2 && exp_q.size() > 0; i++) waitTick();

        repeat (20) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'($urandom), 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
        checkOutput("underrun_cleared", int'(underrun), 0);
        waitTick();
        waitTick();
        repeat (3) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("underrun_set", int'(underrun), 1);
        waitTick();
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
        checkOutput("underrun_set_wins", int'(underrun), 1);
        repeat (5) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
        checkOutput("underrun_cleared_again", int'(underrun), 0);

        waitTick();
        applyStimulus(1'b1, 16'($urandom), 1'b1, 1'b0);
        checkOutput("push_pop_at_empty", int'(fifo_level), 1);
        waitTick();
        for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b1, 16'($urandom), 1'b1, 1'b0);
        waitTick();
        applyStimulus(1'b1, 16'($urandom), 1'b1, 1'b0);
        checkOutput("push_pop_at_depth_minus1", int'(fifo_level), DEPTH - 1);
        for (int i = 0; i < DEPTH + 1; i++) waitTick();

        repeat (560) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        resetDut(1'b0);

        rv = 1'b0;
        rd = '0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 12 * TICK_DIV; c++) begin
                if (!rv) begin
                    rv = ($urandom_range(ph == 0 ? 199 : 899) == 0);
                    rd = 16'($urandom);
                end
                applyStimulus(rv, rd, 1'b1, ($urandom_range(499) == 0));
                if (acc_pend) rv = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
